// File: rtl/fetch_responder.sv
// Fetch-stage responder: one imem read per fetch_enable pulse, 1-cycle fetch_done with instr/pc.
// Enable-to-done is at least 3 cycles; waits indefinitely on imem_ready/imem_rvalid; flush drains without done.
module fetch_responder #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_enable,
  input  logic              stall_enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              fetch_done,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              proto_err,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_next_q, pc_next_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic                done_q, done_d;
  logic                proto_err_q, proto_err_d;
  logic                pending_q, pending_d;

  logic                start;
  logic                pend_eff;
  logic                capture;
  logic [ADDR_W-1:0]   fetch_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_next_q   <= RESET_PC;
      addr_q      <= '0;
      instr_q     <= '0;
      pc_out_q    <= '0;
      done_q      <= 1'b0;
      proto_err_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_next_q   <= pc_next_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      done_q      <= done_d;
      proto_err_q <= proto_err_d;
      pending_q   <= pending_d;
    end
  end

  // Flush always wins: it cancels a new enable and any pending restart.
  assign start      = (state_q == IDLE) && fetch_enable && !stall_enable;
  assign pend_eff   = !stall_enable && (pending_q || fetch_enable);
  assign capture    = (state_q == WAIT) && imem_rvalid && !stall_enable;
  assign fetch_addr = redirect_valid ? redirect_addr : pc_next_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ: begin
        if (stall_enable)    state_d = imem_ready ? DRAIN : IDLE;
        else if (imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (stall_enable)     state_d = imem_rvalid ? IDLE : DRAIN;
        else if (imem_rvalid) state_d = IDLE;
      end
      DRAIN:   if (imem_rvalid) state_d = pend_eff ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    pc_next_d   = pc_next_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    done_d      = 1'b0;
    proto_err_d = proto_err_q;
    pending_d   = 1'b0;

    if (capture) begin
      instr_d   = imem_rdata;
      pc_out_d  = addr_q;
      pc_next_d = addr_q + ADDR_W'(PC_STEP);
      done_d    = 1'b1;
    end
    if (redirect_valid) pc_next_d = redirect_addr;

    if ((state_q == REQ || state_q == WAIT) && fetch_enable && !stall_enable)
      proto_err_d = 1'b1;

    case (state_q)
      IDLE:  if (start) addr_d = fetch_addr;
      DRAIN: begin
        if (imem_rvalid) begin
          if (pend_eff) addr_d = fetch_addr;
        end else begin
          pending_d = pend_eff;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == REQ);
    busy       = (state_q != IDLE);
    imem_addr  = addr_q;
    fetch_done = done_q;
    instr      = instr_q;
    pc_out     = pc_out_q;
    proto_err  = proto_err_q;
  end

endmodule

// File: tb/tb_fetch_responder.sv
// Directed table of per-cycle inputs and hand-computed outputs, plus a reactive-memory fetch sequence.
module tb_fetch_responder;

  logic        clk = 1'b0;
  logic        rst, fetch_enable, stall_enable, redirect_valid;
  logic [31:0] redirect_addr;
  logic        fetch_done, busy, proto_err, imem_req;
  logic [31:0] instr, pc_out, imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_responder dut (
    .clk(clk), .rst(rst), .fetch_enable(fetch_enable), .stall_enable(stall_enable),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_done(fetch_done), .instr(instr), .pc_out(pc_out), .busy(busy),
    .proto_err(proto_err), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  typedef struct {
    logic        rst, fe, se, rv;
    logic [31:0] raddr;
    logic        rdy, rvl;
    logic [31:0] rdata;
    logic        done;
    logic [31:0] instr, pc;
    logic        req;
    logic [31:0] addr;
    logic        busy, perr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rst_i, fe, se, rv, input logic [31:0] raddr,
    input logic rdy, rvl, input logic [31:0] rdata,
    input logic done, input logic [31:0] ins, pc, input logic req,
    input logic [31:0] addr, input logic bsy, perr);
    vec_t r;
    r.rst = rst_i; r.fe = fe; r.se = se; r.rv = rv; r.raddr = raddr;
    r.rdy = rdy; r.rvl = rvl; r.rdata = rdata;
    r.done = done; r.instr = ins; r.pc = pc; r.req = req; r.addr = addr;
    r.busy = bsy; r.perr = perr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    bit got;
    bit acc;
    rst = 1'b1; fetch_enable = 1'b0; stall_enable = 1'b0; redirect_valid = 1'b0;
    redirect_addr = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    //            rst fe se rv raddr         rdy rvl rdata         done instr         pc            req addr          busy perr
    // basic fetch, then next sequential address
    tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hDEADBEEF, 32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hDEADBEEF, 32'h0,        1, 32'h4,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hDEADBEEF, 32'h0,        0, 32'h4,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'h11111111, 1, 32'h11111111, 32'h4,        0, 32'h4,        0, 0));
    // reset, then imem_ready held low for 5 cycles
    tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        1, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(v(0, 0, 0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hCAFEF00D, 32'h0,        0, 32'h0,        0, 0));
    // flush in WAIT, enable during DRAIN, restart at 4 on drain exit
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hCAFEF00D, 32'h0,        1, 32'h4,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hCAFEF00D, 32'h0,        0, 32'h4,        1, 0));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hCAFEF00D, 32'h0,        0, 32'h4,        1, 0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hCAFEF00D, 32'h0,        0, 32'h4,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'h00001234, 0, 32'hCAFEF00D, 32'h0,        1, 32'h4,        1, 0));
    // redirect coincident with rvalid beats +4
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hCAFEF00D, 32'h0,        0, 32'h4,        1, 0));
    tbl.push_back(v(0, 0, 0, 1, 32'h100,      0, 1, 32'h55AA55AA, 1, 32'h55AA55AA, 32'h4,        0, 32'h4,        0, 0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h55AA55AA, 32'h4,        1, 32'h100,      1, 0));
    // enable in WAIT raises sticky proto_err; enable+flush in IDLE does nothing
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h55AA55AA, 32'h4,        0, 32'h100,      1, 0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h55AA55AA, 32'h4,        0, 32'h100,      1, 1));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'h0BADF00D, 1, 32'h0BADF00D, 32'h100,      0, 32'h100,      0, 1));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0BADF00D, 32'h100,      0, 32'h100,      0, 1));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0BADF00D, 32'h100,      0, 32'h100,      0, 1));
    // PC wrap, then reset while in WAIT and a stale rvalid afterwards
    tbl.push_back(v(0, 1, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        0, 32'h0BADF00D, 32'h100,      1, 32'hFFFFFFFC, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0BADF00D, 32'h100,      0, 32'hFFFFFFFC, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'h13579BDF, 1, 32'h13579BDF, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h13579BDF, 32'hFFFFFFFC, 1, 32'h0,        1, 1));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h13579BDF, 32'hFFFFFFFC, 0, 32'h0,        1, 1));
    tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'hEEEEEEEE, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0));
    // flush in REQ with ready (drain), flush in REQ without ready, flush with rvalid in WAIT
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 1, 32'h00000077, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        1, 0));
    tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 1, 32'h00000099, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0));

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; fetch_enable = tbl[i].fe; stall_enable = tbl[i].se;
      redirect_valid = tbl[i].rv; redirect_addr = tbl[i].raddr;
      imem_ready = tbl[i].rdy; imem_rvalid = tbl[i].rvl; imem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("row%0d_done", i),  32'(fetch_done), 32'(tbl[i].done));
      chk($sformatf("row%0d_instr", i), instr,           tbl[i].instr);
      chk($sformatf("row%0d_pc", i),    pc_out,          tbl[i].pc);
      chk($sformatf("row%0d_req", i),   32'(imem_req),   32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i),  imem_addr,       tbl[i].addr);
      chk($sformatf("row%0d_busy", i),  32'(busy),       32'(tbl[i].busy));
      chk($sformatf("row%0d_perr", i),  32'(proto_err),  32'(tbl[i].perr));
    end
    rst = 0; fetch_enable = 0; stall_enable = 0; redirect_valid = 0;
    imem_ready = 0; imem_rvalid = 0;

    // Reactive memory: ready after two stalled cycles, rvalid the cycle after acceptance.
    fetch_enable = 1'b1;
    @(negedge clk);
    fetch_enable = 1'b0;
    got = 1'b0;
    acc = 1'b0;
    imem_rdata = 32'hA5A5A5A5;
    for (int k = 0; k < 20 && !got; k++) begin
      imem_ready  = imem_req && (k >= 2);
      imem_rvalid = acc;
      acc         = imem_ready;
      @(negedge clk);
      if (fetch_done) got = 1'b1;
    end
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    chk("hs_done_within_bound", 32'(got), 32'd1);
    chk("hs_instr", instr, 32'hA5A5A5A5);
    chk("hs_pc_out", pc_out, 32'h0);
    @(negedge clk);
    chk("hs_done_single_pulse", 32'(fetch_done), 32'd0);
    fetch_enable = 1'b1;
    @(negedge clk);
    fetch_enable = 1'b0;
    chk("hs_next_req", 32'(imem_req), 32'd1);
    chk("hs_next_addr", imem_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
